// File: rtl/ulisp_uart.sv
// UART peripheral on the ulisp register bus: index 0 is the TX/RX data console,
// index 1 is status with write-1-to-clear sticky flags. Serial format is 8N1.
module ulisp_uart #(
    parameter int CLOCKS_PER_BIT = 16,
    parameter int TX_FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] register_index,
    input  logic        register_read,
    input  logic        register_write,
    input  logic [15:0] register_write_value,
    output logic [15:0] register_read_value,
    output logic        uart_tx,
    input  logic        uart_rx
);
    localparam int AW = $clog2(TX_FIFO_DEPTH);
    localparam int CW = $clog2(CLOCKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_HALF = CW'(CLOCKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    logic              sel0_s, sel1_s, wr0_s, rd0_s, wr1_s;
    logic [7:0]        fifo_mem_q [TX_FIFO_DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic              full_s, empty_s, push_s, pop_s, tx_idle_s;
    uart_state_e       tx_state_q, tx_state_d;
    logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
    logic [2:0]        tx_bit_q, tx_bit_d;
    logic [7:0]        tx_shift_q, tx_shift_d;
    logic              tx_q, tx_d;
    logic              sync1_q, sync2_q;
    uart_state_e       rx_state_q, rx_state_d;
    logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
    logic [2:0]        rx_bit_q, rx_bit_d;
    logic [7:0]        rx_shift_q, rx_shift_d;
    logic              rx_armed_q, rx_armed_d;
    logic              byte_done_s, frame_err_s;
    logic [7:0]        rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              rx_overrun_q, rx_overrun_d;
    logic              tx_overrun_q, tx_overrun_d;
    logic              framing_q, framing_d;

    assign sel0_s    = (register_index == 12'd0);
    assign sel1_s    = (register_index == 12'd1);
    assign wr0_s     = register_write & sel0_s;
    assign rd0_s     = register_read & sel0_s;
    assign wr1_s     = register_write & sel1_s;
    assign empty_s   = (wr_ptr_q == rd_ptr_q);
    assign full_s    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    // A full FIFO rejects a push even when a pop happens on the same edge.
    assign push_s    = wr0_s & ~full_s;
    assign tx_idle_s = empty_s && (tx_state_q == ST_IDLE);
    assign uart_tx   = tx_q;

    // TX frame sequencer; pops the next byte at the end of STOP so frames run back to back
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        pop_s      = 1'b0;
        case (tx_state_q)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s      = 1'b1;
                    tx_shift_d = fifo_mem_q[rd_ptr_q[AW-1:0]];
                    tx_state_d = ST_START;
                    tx_cnt_d   = '0;
                    tx_d       = 1'b0;
                end else begin
                    tx_d = 1'b1;
                end
            end
            ST_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_state_d = ST_DATA;
                    tx_cnt_d   = '0;
                    tx_bit_d   = 3'd0;
                    tx_d       = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = ST_STOP;
                        tx_d       = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_d       = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (!empty_s) begin
                        pop_s      = 1'b1;
                        tx_shift_d = fifo_mem_q[rd_ptr_q[AW-1:0]];
                        tx_state_d = ST_START;
                        tx_d       = 1'b0;
                    end else begin
                        tx_state_d = ST_IDLE;
                        tx_d       = 1'b1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: begin
                tx_state_d = ST_IDLE;
                tx_d       = 1'b1;
            end
        endcase
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // RX frame sampler; after any frame the line must be seen high before a new start bit
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_armed_d  = rx_armed_q;
        byte_done_s = 1'b0;
        frame_err_s = 1'b0;
        case (rx_state_q)
            ST_IDLE: begin
                if (!sync2_q && rx_armed_q) begin
                    rx_state_d = ST_START;
                    rx_cnt_d   = '0;
                end else begin
                    rx_armed_d = rx_armed_q | sync2_q;
                end
            end
            ST_START: begin
                if (rx_cnt_q == BIT_HALF) begin
                    rx_cnt_d = '0;
                    rx_bit_d = 3'd0;
                    if (sync2_q) begin
                        rx_state_d = ST_IDLE;
                    end else begin
                        rx_state_d = ST_DATA;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {sync2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = ST_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d    = '0;
                    rx_state_d  = ST_IDLE;
                    rx_armed_d  = 1'b0;
                    byte_done_s = sync2_q;
                    frame_err_s = ~sync2_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: begin
                rx_state_d = ST_IDLE;
            end
        endcase
    end

    // RX data and sticky flags; a new byte outranks a same-edge read clear
    always_comb begin
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        rx_overrun_d = rx_overrun_q & ~(wr1_s & register_write_value[3]);
        tx_overrun_d = tx_overrun_q & ~(wr1_s & register_write_value[4]);
        framing_d    = framing_q & ~(wr1_s & register_write_value[5]);
        if (rd0_s) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end
        if (byte_done_s) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !rd0_s) begin
                rx_overrun_d = 1'b1;
            end else begin
                rx_overrun_d = rx_overrun_d;
            end
        end else begin
            rx_data_d = rx_data_q;
        end
        if (frame_err_s) begin
            framing_d = 1'b1;
        end else begin
            framing_d = framing_d;
        end
        if (wr0_s && full_s) begin
            tx_overrun_d = 1'b1;
        end else begin
            tx_overrun_d = tx_overrun_d;
        end
    end

    // Register read mux
    always_comb begin
        case (register_index)
            12'd0:   register_read_value = {8'h00, rx_data_q};
            12'd1:   register_read_value = {10'd0, framing_q, tx_overrun_q, rx_overrun_q,
                                            rx_valid_q, tx_idle_s, full_s};
            default: register_read_value = 16'h0000;
        endcase
    end

    // FIFO storage needs no reset; pointers define which entries are live
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_q[wr_ptr_q[AW-1:0]] <= register_write_value[7:0];
        end
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            tx_state_q   <= ST_IDLE;
            tx_cnt_q     <= '0;
            tx_bit_q     <= 3'd0;
            tx_shift_q   <= 8'h00;
            tx_q         <= 1'b1;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            rx_state_q   <= ST_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= 3'd0;
            rx_shift_q   <= 8'h00;
            rx_armed_q   <= 1'b0;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
            tx_overrun_q <= 1'b0;
            framing_q    <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_bit_q     <= tx_bit_d;
            tx_shift_q   <= tx_shift_d;
            tx_q         <= tx_d;
            sync1_q      <= uart_rx;
            sync2_q      <= sync1_q;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_armed_q   <= rx_armed_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_overrun_q <= rx_overrun_d;
            tx_overrun_q <= tx_overrun_d;
            framing_q    <= framing_d;
        end
    end
endmodule

// File: tb/tb_ulisp_uart.sv
// Directed bench for ulisp_uart at CLOCKS_PER_BIT=4: TX framing and FIFO overrun,
// RX receive/overrun/glitch/framing, and asynchronous reset mid-frame.
module tb_ulisp_uart;
    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] register_index;
    logic        register_read;
    logic        register_write;
    logic [15:0] register_write_value;
    logic [15:0] register_read_value;
    logic        uart_tx;
    logic        uart_rx;

    int n_checks = 0;
    int n_pass   = 0;
    logic txw [400];

    ulisp_uart #(.CLOCKS_PER_BIT(4), .TX_FIFO_DEPTH(8)) dut (
        .clk                  (clk),
        .reset                (reset),
        .register_index       (register_index),
        .register_read        (register_read),
        .register_write       (register_write),
        .register_write_value (register_write_value),
        .register_read_value  (register_read_value),
        .uart_tx              (uart_tx),
        .uart_rx              (uart_rx)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [11:0] idx, input logic [15:0] val);
        @(negedge clk);
        register_index       = idx;
        register_write_value = val;
        register_write       = 1'b1;
        @(negedge clk);
        register_write       = 1'b0;
    endtask

    task automatic do_read(input logic [11:0] idx, output logic [15:0] val);
        @(negedge clk);
        register_index = idx;
        register_read  = 1'b1;
        #1 val = register_read_value;
        @(negedge clk);
        register_read  = 1'b0;
    endtask

    task automatic get_status(output logic [15:0] val);
        register_index = 12'd1;
        #1 val = register_read_value;
    endtask

    task automatic send_rx(input logic [7:0] data, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, data, 1'b0};
        for (int b = 0; b < 10; b++) begin
            uart_rx = frame[b];
            repeat (4) @(negedge clk);
        end
        uart_rx = 1'b1;
    endtask

    initial begin
        logic [15:0] v;
        logic [9:0]  w;
        int          lows;
        logic [9:0]  exp_t1;

        reset = 1'b1; register_index = 12'd0; register_read = 1'b0;
        register_write = 1'b0; register_write_value = 16'h0000; uart_rx = 1'b1;
        #1;
        check_eq("reset_tx", {15'd0, uart_tx}, 16'h0001);
        get_status(v);
        check_eq("reset_status", v, 16'h0002);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        do_read(12'd0, v);
        check_eq("reset_rxdata", v, 16'h0000);
        do_read(12'd7, v);
        check_eq("unmapped_read", v, 16'h0000);

        // Single TX frame of 0x41
        do_write(12'd0, 16'h0041);
        check_eq("tx_pre_start", {15'd0, uart_tx}, 16'h0001);
        @(negedge clk);
        check_eq("tx_latency", {15'd0, uart_tx}, 16'h0000);
        exp_t1 = 10'b1_0100_0001_0;
        @(negedge clk);
        for (int b = 0; b < 10; b++) begin
            if (b != 0) repeat (4) @(negedge clk);
            check_eq($sformatf("tx41_bit%0d", b), {15'd0, uart_tx}, {15'd0, exp_t1[b]});
        end
        repeat (3) @(negedge clk);
        get_status(v);
        check_eq("tx41_idle", v, 16'h0002);

        // Burst of 10 writes: 0x30..0x38 accepted, 0x39 dropped
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    register_index       = 12'd0;
                    register_write_value = 16'h0030 + 16'(i);
                    register_write       = 1'b1;
                end
                @(negedge clk);
                register_write = 1'b0;
                get_status(v);
                check_eq("burst_full_ovr", v, 16'h0011);
            end
            begin
                for (int k = 0; k < 400; k++) begin
                    @(negedge clk);
                    txw[k] = uart_tx;
                end
            end
        join
        for (int f = 0; f < 9; f++) begin
            for (int b = 0; b < 10; b++) w[b] = txw[3 + 40 * f + 4 * b];
            check_eq($sformatf("burst_frame%0d", f), {6'd0, w},
                     {6'd0, 1'b1, 8'h30 + 8'(f), 1'b0});
        end
        check_eq("burst_no_extra", {15'd0, txw[3 + 40 * 9]}, 16'h0001);
        get_status(v);
        check_eq("burst_done_status", v, 16'h0012);
        do_write(12'd1, 16'h0010);
        get_status(v);
        check_eq("txovr_clear", v, 16'h0002);

        // Receive 0x5A
        @(negedge clk);
        send_rx(8'h5A, 1'b1);
        repeat (4) @(negedge clk);
        get_status(v);
        check_eq("rx5a_valid", v, 16'h0006);
        do_read(12'd0, v);
        check_eq("rx5a_data", v, 16'h005A);
        get_status(v);
        check_eq("rx5a_cleared", v, 16'h0002);

        // Two frames without a read: overrun, newest byte kept
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        repeat (4) @(negedge clk);
        do_read(12'd0, v);
        check_eq("rx_ovr_data", v, 16'h0022);
        get_status(v);
        check_eq("rx_ovr_status", v, 16'h000A);
        do_write(12'd1, 16'h0008);
        get_status(v);
        check_eq("rxovr_clear", v, 16'h0002);

        // One-cycle start-bit glitch is ignored
        @(negedge clk);
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (50) @(negedge clk);
        get_status(v);
        check_eq("rx_glitch", v, 16'h0002);

        // Stop bit of 0 raises framing error only
        send_rx(8'h33, 1'b0);
        repeat (4) @(negedge clk);
        get_status(v);
        check_eq("rx_framing", v, 16'h0022);
        do_write(12'd1, 16'h0020);
        get_status(v);
        check_eq("framing_clear", v, 16'h0002);

        // Asynchronous reset during TX data bits
        do_write(12'd0, 16'h0000);
        do_write(12'd0, 16'h0066);
        do_write(12'd0, 16'h0077);
        repeat (5) @(negedge clk);
        check_eq("mid_frame_low", {15'd0, uart_tx}, 16'h0000);
        #1 reset = 1'b1;
        #1;
        check_eq("async_reset_tx", {15'd0, uart_tx}, 16'h0001);
        @(negedge clk);
        reset = 1'b0;
        get_status(v);
        check_eq("post_reset_status", v, 16'h0002);
        lows = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!uart_tx) lows++;
        end
        check_eq("post_reset_silent", 16'(lows), 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ulisp_uart.md
Name: ulisp_uart

Overview:
- Memory-mapped UART peripheral on the ulisp core's register bus (register_index / register_read / register_write), directly downstream of the core's register port.
- Register 0 is the console: bytes written there are queued and serialised 8N1 on uart_tx.
- Received serial bytes are buffered and read back through the same port.
- Replaces the bench-side printing of register-0 writes with real hardware.

Parameters:
- CLOCKS_PER_BIT, 16: clk cycles per serial bit; must be an even number ≥ 4.
- TX_FIFO_DEPTH, 8: TX FIFO entries; must be a power of 2.

Ports:
- clk  in  1: core clock; all state is updated on its rising edge.
- reset  in  1: asynchronous, active-high reset.
- register_index  in  12: register address from the core.
- register_read  in  1: read strobe; read side effects occur on the clk edge where it is high.
- register_write  in  1: write strobe.
- register_write_value  in  16: write data.
- register_read_value  out  16: read data; combinational function of register_index and current state.
- uart_tx  out  1: serial output; idles high.
- uart_rx  in  1: serial input; asynchronous to clk.

Behaviour:
- Register map (all other indices read 0; writes to them are ignored):
  - Index 0 write: push register_write_value[7:0] into the TX FIFO. If the FIFO is full, the byte is dropped and tx_overrun is set.
  - Index 0 read: value = {8'h00, rx_data}. The read edge clears rx_valid.
  - Index 1 read (status): bit0 tx_full, bit1 tx_idle (FIFO empty and TX FSM in IDLE), bit2 rx_valid, bit3 rx_overrun, bit4 tx_overrun, bit5 framing_error; bits 15:6 read 0.
  - Index 1 write: write-1-to-clear for bits 3, 4 and 5; other bits are ignored.
- Simultaneous register_read and register_write in the same cycle: both effects apply.
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - uart_tx=1; FIFO empty; TX and RX FSMs to IDLE; rx_data=0; all flags 0.
  - Status therefore reads 0x0002.
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE with FIFO non-empty: pop the head into the shift register, go to START. uart_tx goes low on the edge after the one that wrote an empty FIFO, i.e. 1 cycle latency.
  - START: 1 bit time low.
  - DATA: 8 bits, LSB first, 1 bit time each.
  - STOP: 1 bit time high, then IDLE.
  - A frame lasts 10×CLOCKS_PER_BIT cycles.
  - Back-to-back frames: pop at the end of STOP, so no idle gap is inserted.
  - Bit counter 0..CLOCKS_PER_BIT-1; bit index 0..7.
- TX FIFO:
  - Circular buffer with read/write pointers one bit wider than the address; they wrap modulo 2×depth.
  - Full when the addresses are equal and the extra bits differ.
  - Push on a full FIFO is dropped even if a pop happens in the same cycle. This keeps the full check combinational on pre-edge state.
- RX path:
  - uart_rx passes through a 2-flop synchroniser reset to 1.
  - RX FSM, states IDLE, START, DATA, STOP:
    - IDLE: wait for synchronised 0.
    - START: sample at CLOCKS_PER_BIT/2. If 1, it was a glitch; return to IDLE. If 0, go to DATA.
    - DATA: 8 samples at full-bit intervals, LSB first.
    - STOP: sample 1 bit later.
  - Stop sample = 1: load rx_data and set rx_valid. If rx_valid was already 1 and is not being cleared by a read on this same edge, also set rx_overrun; the new byte overwrites rx_data.
  - Stop sample = 0: discard the byte and set framing_error.
  - Either way, return to IDLE, then wait for the line to be high before accepting a new start bit.
  - New byte and a reg-0 read on the same edge: the new byte wins, rx_valid stays 1, no overrun.
- Sticky flags are cleared only by reset or a write-1-to-clear to index 1.

Test Plan (CLOCKS_PER_BIT=4):
- Write 0x0041 to index 0, then sample uart_tx every 4 cycles. Required: 0, 1,0,0,0,0,0,1,0, 1. uart_tx first goes low 1 cycle after the write. Status reads 0x0002 again 40 cycles later.
- 10 back-to-back writes to index 0 (0x30..0x39):
  - After the 10th, status bit0=1 and bit4=1.
  - Only 0x30..0x38 appear on uart_tx, contiguously, with no gaps.
  - Write 0x0010 to index 1: bit4 clears.
- Drive an 8N1 frame of 0x5A on uart_rx. Status bit2=1. Index 0 read returns 0x005A; status bit2=0 afterwards.
- Two frames, 0x11 then 0x22, with no read in between:
  - Index 0 reads 0x0022; status bit3=1.
  - Write 0x0008 to index 1: bit3 clears.
  - Start-bit glitch shorter than 2 cycles: no byte is received.
- Frame with stop bit 0: rx_valid stays 0, bit5=1.
- Assert reset mid-DATA of a TX frame: uart_tx=1 the same cycle, without waiting for a clock edge. After release, status=0x0002 and the queued bytes are never sent.
